sha256_w_expander_stream: RTL
=============================

# sha256_w_expander_stream

Streaming, parametrised SHA-256 message-schedule expander for the double-SHA256 pipeline. Accepts one 512-bit block over a valid/ready handshake, holds a 16-word sliding window, and emits the full schedule W0..W(ROUNDS-1), LANES words per beat, under output backpressure. It replaces the fixed per-stage window registers with one reusable, back-pressurable source feeding the compression rounds.

## Interface
- LANES, 1: words emitted per beat; legal 1, 2, 4.
- ROUNDS, 64: schedule length; multiple of LANES, 16..64.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous abort; discards the current block.
- in_valid  in  1  block_in valid.
- in_ready  out  1  block accepted when in_valid && in_ready.
- block_in  in  512  message block; W0 = [511:480], W15 = [31:0].
- out_valid  out  1  w_out valid.
- out_ready  in  1  consumer accepts beat.
- w_out  out  32*LANES  lane k = [32k+31:32k] = W(round_idx+k).
- round_idx  out  6  index of lane 0 word.
- last  out  1  current beat carries W(ROUNDS-1).
- busy  out  1  a block is loaded (RUN state).

## Operation
- States: IDLE, RUN.
- IDLE: in_ready=1, out_valid=0. On in_valid: load window[0..15] = W0..W15 from block_in, round_idx=0, go to RUN.
- RUN: out_valid=1; w_out lanes = window[0..LANES-1]; round_idx = t.
- Beat fire (out_valid && out_ready): window shifts down by LANES; window[16-LANES..15] receives W(t+16)..W(t+15+LANES); t += LANES.
- New word: W(j) = s1(W(j-2)) + W(j-7) + s0(W(j-15)) + W(j-16), mod 2^32. s0(x) = ror7^ror18^shr3; s1(x) = ror17^ror19^shr10. For LANES>=3, lanes k>=2 use words computed earlier in the same cycle (combinational chain).
- last = RUN && (t + LANES == ROUNDS).
- Fire with last: if in_valid, load the new block the same cycle and stay in RUN with t=0 (back-to-back); otherwise go to IDLE.
- in_ready = IDLE || (out_valid && out_ready && last). This path is combinational from out_ready.
- flush: highest priority. Next state is IDLE; in_ready=0 and no load occur in that cycle; window and t are cleared. A beat presented in the flush cycle does not count as fired, even if out_ready=1.
- Stall: while out_valid && !out_ready, w_out, round_idx and last hold stable.

## Timing
- Reset values: out_valid 0, last 0, busy 0, round_idx 0, w_out 0 (window cleared), in_ready 1 (IDLE).
- Latency: accept in cycle N, then first beat (W0..) valid in cycle N+1.
- Throughput: ROUNDS/LANES beats per block with no stall; back-to-back blocks have zero bubble.
- Reset mid-block: immediate return to IDLE; the partial schedule is lost and no further beats are emitted.
- Simultaneous flush and in_valid: the block is not accepted.
- Simultaneous flush and RST: RST dominates; the resulting state is the same.
- round_idx wraps to 0 only by a new load, never by increment.

## Structure
- sha256_pkg: word_t (32-bit), functions sigma0/sigma1, localparam WINDOW=16, state enum {IDLE, RUN}.
- Sub-module sha256_w_next: combinational, four word inputs, one word output (the recurrence). Instantiate it LANES times, chained.
- Top level: window registers, t counter, FSM, handshake.

## Test plan
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), LANES=1, out_ready=1 -> 64 beats; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6; last only on round_idx=63; all 64 words match the golden model.
- Same block, LANES=4 -> 16 beats; beat 4 = {0x600003C6, 0x7DA86405, 0x000F0000, 0x61626380} (lane 3..0); round_idx 0, 4, …, 60.
- Random out_ready (≈50%) -> w_out/round_idx/last stable during stalls; word sequence identical to the no-stall run.
- Two blocks with in_valid held -> second block accepted on the last-beat fire; next cycle round_idx=0 with the new W0; no idle cycle.
- flush asserted at round_idx=20 -> IDLE next cycle, out_valid=0, in_ready=1; a new block then restarts at W0 correctly.
- RST asserted asynchronously mid-RUN -> outputs take reset values immediately; beats resume only after a new load.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and helpers for the SHA-256 message-schedule logic.
//   word_t   : 32-bit schedule word
//   Window   : depth of the sliding schedule window (W(t)..W(t+15))
//   state_e  : expander FSM states
//   sigma0/1 : small-sigma functions of the schedule recurrence
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned Window = 16;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  function automatic word_t ror(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_next.sv
// One step of the SHA-256 schedule recurrence, purely combinational.
//   w_m2_i  : W(j-2)
//   w_m7_i  : W(j-7)
//   w_m15_i : W(j-15)
//   w_m16_i : W(j-16)
//   w_o     : W(j) = sigma1(W(j-2)) + W(j-7) + sigma0(W(j-15)) + W(j-16), mod 2^32
module sha256_w_next
  import sha256_pkg::*;
(
  input  word_t w_m2_i,
  input  word_t w_m7_i,
  input  word_t w_m15_i,
  input  word_t w_m16_i,
  output word_t w_o
);

  assign w_o = sigma1(w_m2_i) + w_m7_i + sigma0(w_m15_i) + w_m16_i;

endmodule

// File: rtl/sha256_w_expander_stream.sv
// Streaming SHA-256 message-schedule expander.
// Takes one 512-bit block over a valid/ready handshake and emits W0..W(ROUNDS-1),
// LANES words per beat, under output backpressure.
//   CLK, RST   : clock, asynchronous active-high reset
//   flush      : synchronous abort of the current block
//   in_valid / in_ready / block_in : block input (W0 = [511:480])
//   out_valid / out_ready / w_out  : schedule output, lane k = W(round_idx+k)
//   round_idx  : index of the lane 0 word
//   last       : current beat carries W(ROUNDS-1)
//   busy       : a block is loaded
module sha256_w_expander_stream
  import sha256_pkg::*;
#(
  parameter int unsigned LANES  = 1,
  parameter int unsigned ROUNDS = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [511:0]          block_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   w_out,
  output logic [5:0]            round_idx,
  output logic                  last,
  output logic                  busy
);

  // 7 bits so that t + LANES can reach ROUNDS (64) without overflow.
  localparam logic [6:0] LanesW  = 7'(LANES);
  localparam logic [6:0] RoundsW = 7'(ROUNDS);

  state_e     state_q, state_d;
  word_t      window_q [Window];
  word_t      window_d [Window];
  logic [6:0] t_q, t_d;
  word_t      new_w [LANES];

  logic fire;
  logic accept;

  // Lane k produces W(t+16+k). Lanes 2 and 3 need W(t+14+k), which is a word
  // produced by lane k-2 in this same cycle, hence the combinational chain.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    word_t w_m2;
    word_t w_new;

    if (k < 2) begin : g_win
      assign w_m2 = window_q[14+k];
    end else begin : g_chain
      assign w_m2 = g_lane[k-2].w_new;
    end

    sha256_w_next u_w_next (
      .w_m2_i  (w_m2),
      .w_m7_i  (window_q[9+k]),
      .w_m15_i (window_q[1+k]),
      .w_m16_i (window_q[k]),
      .w_o     (w_new)
    );

    assign new_w[k]            = w_new;
    assign w_out[32*k +: 32]   = window_q[k];
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. flush beats everything, including a pending load.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else if (accept) begin
      state_d = StRun;
    end else if (fire && last) begin
      state_d = StIdle;
    end
  end

  // Output logic.
  always_comb begin
    out_valid = (state_q == StRun);
    busy      = (state_q == StRun);
    last      = (state_q == StRun) && ((t_q + LanesW) == RoundsW);
    // A beat presented while flush is high never counts as fired.
    fire      = out_valid && out_ready && !flush;
    // Combinational from out_ready so a new block can follow the last beat with no bubble.
    in_ready  = !flush && ((state_q == StIdle) || (fire && last));
    accept    = in_valid && in_ready;
    round_idx = t_q[5:0];
  end

  // Window and round counter next state.
  always_comb begin
    window_d = window_q;
    t_d      = t_q;
    if (flush) begin
      for (int i = 0; i < Window; i++) window_d[i] = '0;
      t_d = '0;
    end else if (accept) begin
      for (int i = 0; i < Window; i++) window_d[i] = block_in[511 - 32*i -: 32];
      t_d = '0;
    end else if (fire && last) begin
      // Schedule complete: return to the same cleared state as after reset.
      for (int i = 0; i < Window; i++) window_d[i] = '0;
      t_d = '0;
    end else if (fire) begin
      for (int i = 0; i < Window - LANES; i++) window_d[i] = window_q[i + LANES];
      for (int k = 0; k < LANES; k++) window_d[Window - LANES + k] = new_w[k];
      t_d = t_q + LanesW;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < Window; i++) window_q[i] <= '0;
      t_q <= '0;
    end else begin
      window_q <= window_d;
      t_q      <= t_d;
    end
  end

endmodule
